// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg : shared types and default widths for sum_accumulator
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;

endpackage : accum_pkg

`default_nettype wire

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator : accumulates a programmed number of adder sums and presents
//                   total, count and sticky overflow on an output handshake.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sum_accumulator
    import accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W:0]     w_sum_ext;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_last;

    // r_in_ready is high exactly while in ACCUM, so it doubles as the state qualifier
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_accept   = r_in_ready && in_valid;
    assign w_cnt_inc  = r_cnt + c_CNT_ONE;
    assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign w_last     = w_accept && (w_cnt_inc == r_len);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it with no decode delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ST_ACCUM);
            r_out_valid <= (w_next == ST_DONE);
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_len <= len;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
            r_acc <= w_sum_ext[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum_ext[ACC_W];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule : sum_accumulator

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator : directed bench for sum_accumulator (ACC_W=16 and ACC_W=10)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [15:0] a_out_sum;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [9:0]  b_out_sum;
    logic [7:0]  b_out_count;

    int n_total = 0;
    int n_bad   = 0;

    // model state: 0 idle, 1 collecting, 2 result held
    int m_phase = 0;
    int m_len   = 0;
    int m_cnt   = 0;
    int m_total = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_count(a_out_count), .out_ovf(a_out_ovf), .busy(a_busy)
    );

    sum_accumulator #(.DATA_W(8), .ACC_W(10), .CNT_W(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_count(b_out_count), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: the running total is an unbounded integer;
    // wrap and overflow are derived from it per accumulator width.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_len = 0; m_cnt = 0; m_total = 0;
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_len = int'(len); m_cnt = 0; m_total = 0;
                        m_phase = (len == 0) ? 2 : 1;
                    end
                    1: if (in_valid) begin
                        m_total += int'(in_data);
                        m_cnt++;
                        if (m_cnt == m_len) m_phase = 2;
                    end
                    default: if (out_ready) m_phase = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready16",  int'(a_in_ready),  int'(m_phase == 1));
        check("out_valid16", int'(a_out_valid), int'(m_phase == 2));
        check("busy16",      int'(a_busy),      int'(m_phase != 0));
        check("sum16",       int'(a_out_sum),   m_total % 65536);
        check("count16",     int'(a_out_count), m_cnt);
        check("ovf16",       int'(a_out_ovf),   int'(m_total >= 65536));
        check("in_ready10",  int'(b_in_ready),  int'(m_phase == 1));
        check("out_valid10", int'(b_out_valid), int'(m_phase == 2));
        check("busy10",      int'(b_busy),      int'(m_phase != 0));
        check("sum10",       int'(b_out_sum),   m_total % 1024);
        check("count10",     int'(b_out_count), m_cnt);
        check("ovf10",       int'(b_out_ovf),   int'(m_total >= 1024));
    end

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 8'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("lit_idle_after_result", int'({a_out_valid, a_busy, b_busy}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("lit_reset_sum", int'(a_out_sum), 0);
        check("lit_reset_flags", int'({a_in_ready, a_out_valid, a_busy, a_out_ovf}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // three back-to-back beats
        do_start(3);
        check("lit_busy_after_start", int'({a_busy, a_in_ready}), 3);
        beat(1); beat(2); beat(3);
        check("lit_t1_valid_ready", int'({a_out_valid, a_in_ready}), 2);
        check("lit_t1_sum", int'(a_out_sum), 6);
        check("lit_t1_count", int'(a_out_count), 3);
        check("lit_t1_ovf", int'(a_out_ovf), 0);
        take_result();

        // all-ones beats: wraps in the narrow instance only
        do_start(5);
        for (int i = 0; i < 5; i++) beat(255);
        check("lit_t2_sum10", int'(b_out_sum), 251);
        check("lit_t2_ovf10", int'(b_out_ovf), 1);
        check("lit_t2_sum16", int'(a_out_sum), 1275);
        check("lit_t2_ovf16", int'(a_out_ovf), 0);
        check("lit_t2_count", int'(b_out_count), 5);
        take_result();

        // zero-length run
        do_start(0);
        check("lit_t3_valid_ready", int'({a_out_valid, a_in_ready}), 2);
        check("lit_t3_sum", int'(a_out_sum), 0);
        check("lit_t3_count", int'(a_out_count), 0);
        take_result();

        // bubbles between beats
        do_start(4);
        beat(10); @(negedge clk);
        beat(20); @(negedge clk);
        beat(30); @(negedge clk);
        beat(40);
        check("lit_t4_sum", int'(a_out_sum), 100);
        check("lit_t4_count", int'(a_out_count), 4);
        take_result();

        // result held with out_ready low, start pulsed during DONE
        do_start(2);
        beat(5); beat(6);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd9;
            end
            @(negedge clk);
            start = 1'b0;
            check("lit_t5_hold_valid", int'(a_out_valid), 1);
            check("lit_t5_hold_sum", int'(a_out_sum), 11);
            check("lit_t5_hold_count", int'(a_out_count), 2);
        end
        take_result();

        // asynchronous reset mid-run, then a short run
        do_start(4);
        beat(1); beat(2);
        #2 rst_n = 1'b0;
        #1;
        check("lit_t6_async_flags", int'({a_busy, a_in_ready, b_busy, b_in_ready}), 0);
        check("lit_t6_async_sum", int'(a_out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(1);
        beat(7);
        check("lit_t6_sum", int'(a_out_sum), 7);
        check("lit_t6_valid", int'(a_out_valid), 1);
        take_result();

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sum_accumulator

`default_nettype wire

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of `multibit_adder`. It takes a stream of 8-bit sums over a valid/ready handshake and accumulates a programmed number of them into a wider running total. It then presents the total, the sample count and an overflow flag on an output handshake. It sits between the combinational adder and any result sink (display driver, register file).

## Interface
Parameters:
- `DATA_W`, 8: width of incoming sum (matches `multibit_adder.out`)
- `ACC_W`, 16: accumulator width; must be ≥ `DATA_W`
- `CNT_W`, 8: width of length/count fields

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a new accumulation
- `len`  in  CNT_W  number of samples to accumulate, sampled with `start`
- `in_valid`  in  1  `in_data` is valid
- `in_data`  in  DATA_W  sum from `multibit_adder.out`
- `in_ready`  out  1  block accepts `in_data` this cycle
- `out_valid`  out  1  result available
- `out_ready`  in  1  sink accepts result
- `out_sum`  out  ACC_W  accumulated total, modulo 2^ACC_W
- `out_count`  out  CNT_W  samples accepted
- `out_ovf`  out  1  sticky: accumulator carried out at least once
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, DONE. All outputs are registered.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`, latch `len`, clear accumulator, count and ovf.
  - If `len`==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`: accumulator += zero-extended `in_data`, count += 1, ovf |= carry out of bit ACC_W-1.
  - Cycles with `in_valid`=0 change nothing.
  - When the accepted beat makes count == latched len, go to DONE. `in_ready` drops in the following cycle.
- DONE:
  - `out_valid`=1. `out_sum`, `out_count` and `out_ovf` hold stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `start` is ignored outside IDLE. `len` is not re-sampled mid-run.
- Arithmetic: unsigned, wraps modulo 2^ACC_W. No saturation.
- `out_sum`, `out_count` and `out_ovf` keep their last values in IDLE until the next `start` clears them.

## Timing
- Reset (asynchronous, any state, including mid-ACCUM or DONE):
  - State goes to IDLE immediately.
  - `in_ready`, `out_valid`, `busy`, `out_ovf` = 0; `out_sum`, `out_count` = 0.
  - The partial run is discarded.
- `start` at edge N: `busy` and `in_ready` are high from cycle N+1 (ACCUM).
- With `len`==0: `out_valid` is high in cycle N+1.
- Last beat accepted at edge M: `out_valid` is high and `in_ready` is low in cycle M+1. Result latency is 1 cycle after the final beat.
- Result handshake completes at edge K: `out_valid` and `busy` are low in cycle K+1. A `start` is honoured from edge K+1 onward.
- Peak throughput: 1 beat/cycle. Minimum run overhead: 1 cycle for start, 1 cycle for result.
- `out_ready` held low: DONE persists indefinitely with outputs stable. `in_data` is not sampled.

## Structure
- Shared package `accum_pkg`:
  - state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2)
  - default `DATA_W`/`ACC_W`/`CNT_W` constants
- No sub-module. The accumulate/count datapath and the FSM are written inline.
- Top-level integration instantiates `multibit_adder` alongside this block; this block does not contain the adder.

## Test plan
- `len`=3, beats 8'd1, 8'd2, 8'd3 back-to-back → `out_sum`=6, `out_count`=3, `out_ovf`=0; `out_valid` rises exactly 1 cycle after the third beat.
- `ACC_W`=10, `len`=5, beats all 8'hFF → `out_sum`=10'd251 (1275 mod 1024), `out_ovf`=1.
- `len`=0 → `out_valid` in the cycle after `start`; `out_sum`=0, `out_count`=0; `in_ready` never asserted.
- `len`=4 with `in_valid` low on alternate cycles (beats 10, 20, 30, 40) → bubbles ignored, `out_sum`=100, `out_count`=4.
- Result reached, `out_ready` low for 5 cycles, `start` pulsed during DONE → outputs stable, `start` ignored; `out_ready` high → IDLE next cycle.
- `rst_n` low after 2 of 4 beats → immediately `busy`=0, `in_ready`=0, `out_sum`=0. After release, `start` with `len`=1 and beat 8'd7 → `out_sum`=7.
